// File: rtl/lut_perm_pkg.sv
// lut_perm_pkg: default sizes, FSM encoding and field helper shared by lut_perm_gen
package lut_perm_pkg;
    localparam int N_DEF  = 7;
    localparam int W_DEF  = 6;
    localparam int CW_DEF = 13;
    localparam int VMAX   = 512;
    typedef logic [2:0] state_t;
    localparam state_t IDLE   = 3'd0;
    localparam state_t EMIT   = 3'd1;
    localparam state_t SCAN_I = 3'd2;
    localparam state_t SCAN_J = 3'd3;
    localparam state_t SWAP   = 3'd4;
    localparam state_t REV    = 3'd5;
    localparam state_t DONE   = 3'd6;
    function automatic logic [31:0] get_fld(input logic [VMAX-1:0] vec, input int k, input int w);
        return 32'(vec >> (k * w)) & ((32'd1 << w) - 32'd1);
    endfunction
endpackage

// File: rtl/lut_perm_swap.sv
// lut_perm_swap: combinational exchange of fields a and b inside an N*W vector
module lut_perm_swap #(
    parameter int N  = 7,
    parameter int W  = 6,
    parameter int AW = 3
) (
    input  logic [N*W-1:0] vec,
    input  logic [AW-1:0]  a,
    input  logic [AW-1:0]  b,
    output logic [N*W-1:0] out
);
    // copy the vector, then cross-write the two selected fields
    always_comb begin
        out = vec;
        out[a*W +: W] = vec[b*W +: W];
        out[b*W +: W] = vec[a*W +: W];
    end
endmodule

// File: rtl/lut_perm_gen.sv
// lut_perm_gen: lexicographic permutation sweep with valid/ready output; LUT_PERM_GEN_IDX_EN adds ordinal port idx
module lut_perm_gen
    import lut_perm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N*W-1:0] seed,
    input  logic         abort,
    output logic [N*W-1:0] prm,
    output logic         vld,
    input  logic         rdy,
    output logic         busy,
    output logic         done
`ifdef LUT_PERM_GEN_IDX_EN
    ,
    output logic [CW-1:0] idx
`endif
);
    localparam int IW = $clog2(N) + 1;
    localparam int AW = IW - 1;
    state_t st;
    logic signed [IW-1:0] i, j, l, r;
    logic [W-1:0] pi, pi1, pj;
    logic [AW-1:0] sa, sb;
    logic [N*W-1:0] swp;
    assign pi  = W'(get_fld(VMAX'(prm), int'(i), W));
    assign pi1 = W'(get_fld(VMAX'(prm), int'(i) + 1, W));
    assign pj  = W'(get_fld(VMAX'(prm), int'(j), W));
    assign sa  = (st == SWAP) ? i[AW-1:0] : l[AW-1:0];
    assign sb  = (st == SWAP) ? j[AW-1:0] : r[AW-1:0];
    lut_perm_swap #(.N(N), .W(W), .AW(AW)) u_swp (.vec(prm), .a(sa), .b(sb), .out(swp));
    // sweep FSM: emit, find pivot, find successor, swap, reverse suffix
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            prm  <= '0;
            vld  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            i    <= '0;
            j    <= '0;
            l    <= '0;
            r    <= '0;
        end else if (abort && st != IDLE) begin
            st   <= IDLE;
            vld  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    prm  <= seed;
                    vld  <= 1'b1;
                    busy <= 1'b1;
                    st   <= EMIT;
                end
                EMIT: if (rdy) begin
                    vld <= 1'b0;
                    i   <= IW'(N - 2);
                    st  <= SCAN_I;
                end
                SCAN_I: if (pi < pi1) begin
                    j  <= IW'(N - 1);
                    st <= SCAN_J;
                end else if (i == 0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    st   <= DONE;
                end else begin
                    i <= i - IW'(1);
                end
                SCAN_J: if (pj > pi) st <= SWAP;
                        else j <= j - IW'(1);
                SWAP: begin
                    prm <= swp;
                    l   <= i + IW'(1);
                    r   <= IW'(N - 1);
                    st  <= REV;
                end
                REV: if (l < r) begin
                    prm <= swp;
                    l   <= l + IW'(1);
                    r   <= r - IW'(1);
                end else begin
                    vld <= 1'b1;
                    st  <= EMIT;
                end
                DONE: begin
                    done <= 1'b0;
                    st   <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
`ifdef LUT_PERM_GEN_IDX_EN
    // ordinal follows prm: cleared on load, bumped as each successor is presented
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idx <= '0;
        else if (st == IDLE && start) idx <= '0;
        else if (st == REV && !(l < r) && !abort) idx <= idx + CW'(1);
    end
`else
    localparam int unused_cw = CW;
`endif
endmodule

// File: tb/tb_lut_perm_gen.sv
// tb_lut_perm_gen: randomized self-checking bench against a brute-force multiset permutation model
module tb_lut_perm_gen;
    import lut_perm_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic st3 = 1'b0, ab3 = 1'b0, rdy3 = 1'b0, vld3, busy3, done3;
    logic [5:0] sd3 = '0, prm3;
    logic st7 = 1'b0, ab7 = 1'b0, rdy7 = 1'b0, vld7, busy7, done7;
    logic [41:0] sd7 = '0, prm7;
`ifdef LUT_PERM_GEN_IDX_EN
    logic [2:0] idx3;
    logic [12:0] idx7;
`endif
    int total = 0, bad = 0;
    logic [41:0] exp_q[$];

    lut_perm_gen #(.N(3), .W(2), .CW(3)) u3 (.clk(clk), .rst(rst), .start(st3), .seed(sd3), .abort(ab3),
        .prm(prm3), .vld(vld3), .rdy(rdy3), .busy(busy3), .done(done3)
`ifdef LUT_PERM_GEN_IDX_EN
        , .idx(idx3)
`endif
    );
    lut_perm_gen u7 (.clk(clk), .rst(rst), .start(st7), .seed(sd7), .abort(ab7),
        .prm(prm7), .vld(vld7), .rdy(rdy7), .busy(busy7), .done(done7)
`ifdef LUT_PERM_GEN_IDX_EN
        , .idx(idx7)
`endif
    );

    function automatic logic [41:0] seq7(input bit desc);
        logic [41:0] v = '0;
        for (int k = 0; k < 7; k++) v = v | (42'(desc ? 6 - k : k) << (k * 6));
        return v;
    endfunction

    // every digit tuple in lexicographic order from the seed onward, kept if it is a rearrangement of the seed
    task automatic build_exp(input int n, input int w, input logic [41:0] sd);
        int s[8];
        int h[64];
        int c[64];
        int base, d;
        longint sn, pw, t;
        logic [41:0] v;
        bit same;
        exp_q.delete();
        base = 1; sn = 0; pw = 1;
        for (int k = 0; k < 64; k++) h[k] = 0;
        for (int k = 0; k < n; k++) begin
            s[k] = int'((sd >> (k * w)) & ((42'd1 << w) - 42'd1));
            h[s[k]]++;
            if (s[k] + 1 > base) base = s[k] + 1;
        end
        for (int k = 0; k < n; k++) begin sn = sn * base + s[k]; pw = pw * base; end
        for (longint m = sn; m < pw; m++) begin
            t = m; v = '0;
            for (int k = 0; k < base; k++) c[k] = 0;
            for (int k = n - 1; k >= 0; k--) begin
                d = int'(t % base);
                c[d]++;
                v = v | (42'(d) << (k * w));
                t = t / base;
            end
            same = 1'b1;
            for (int k = 0; k < base; k++) if (c[k] != h[k]) same = 1'b0;
            if (same) exp_q.push_back(v);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if ({vld3, busy3, done3, prm3} !== 9'd0) begin bad++; $display("FAIL reset_n3 got=%h want=0", {vld3, busy3, done3, prm3}); end
        total++; if ({vld7, busy7, done7} !== 3'd0) begin bad++; $display("FAIL reset_flags7 got=%b want=000", {vld7, busy7, done7}); end
        total++; if (prm7 !== 42'd0) begin bad++; $display("FAIL reset_prm7 got=%h want=0", prm7); end
`ifdef LUT_PERM_GEN_IDX_EN
        total++; if ({idx3, idx7} !== 16'd0) begin bad++; $display("FAIL reset_idx got=%h want=0", {idx3, idx7}); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small;
        int beats = 0, last = 0;
        bit seen = 1'b0;
        build_exp(3, 2, 42'h24);
        sd3 = 6'h24; st3 = 1'b1; rdy3 = 1'b1;
        @(negedge clk); st3 = 1'b0;
        total++; if ({vld3, busy3, prm3} !== {2'b11, 6'h24}) begin bad++; $display("FAIL small_first got=%h want=%h", {vld3, busy3, prm3}, {2'b11, 6'h24}); end
        for (int c = 0; c < 200 && !seen; c++) begin
            if (done3) begin
                seen = 1'b1;
                total++; if (beats !== 6) begin bad++; $display("FAIL small_beats got=%0d want=6", beats); end
                total++; if (busy3 !== 1'b0) begin bad++; $display("FAIL small_busy_at_done got=%b want=0", busy3); end
                total++; if (c - last !== 3) begin bad++; $display("FAIL small_done_latency got=%0d want=3", c - last); end
            end else if (vld3 && rdy3) begin
                total++; if (beats >= exp_q.size() || {36'd0, prm3} !== exp_q[beats]) begin bad++; $display("FAIL small_beat%0d got=%h want=%h", beats, prm3, beats < exp_q.size() ? exp_q[beats] : 42'd0); end
                beats++; last = c;
            end
            @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL small_timeout got=no_done want=done"); end
        total++; if ({done3, busy3, vld3} !== 3'd0) begin bad++; $display("FAIL small_pulse got=%b want=000", {done3, busy3, vld3}); end
    endtask

    task automatic test_full;
        int beats = 0;
        bit seen = 1'b0;
        logic [41:0] lastp = '0;
        build_exp(7, 6, seq7(1'b0));
        sd7 = seq7(1'b0); st7 = 1'b1; rdy7 = 1'b1;
        @(negedge clk); st7 = 1'b0;
        for (int c = 0; c < 60000 && !seen; c++) begin
            if (done7) begin
                seen = 1'b1;
                total++; if (beats !== 5040) begin bad++; $display("FAIL full_beats got=%0d want=5040", beats); end
                total++; if (lastp !== seq7(1'b1)) begin bad++; $display("FAIL full_last got=%h want=%h", lastp, seq7(1'b1)); end
                total++; if (busy7 !== 1'b0) begin bad++; $display("FAIL full_busy got=%b want=0", busy7); end
            end else if (vld7 && rdy7) begin
                total++; if (beats >= exp_q.size() || prm7 !== exp_q[beats]) begin bad++; $display("FAIL full_beat%0d got=%h want=%h", beats, prm7, beats < exp_q.size() ? exp_q[beats] : 42'd0); end
`ifdef LUT_PERM_GEN_IDX_EN
                total++; if (idx7 !== 13'(beats)) begin bad++; $display("FAIL full_idx%0d got=%0d want=%0d", beats, idx7, beats); end
`endif
                lastp = prm7; beats++;
            end
            @(negedge clk);
        end
        total++; if (!seen) begin bad++; $display("FAIL full_timeout got=no_done want=done beats=%0d", beats); end
    endtask

    task automatic test_rand_abort;
        int beats = 0;
        bit pv = 1'b0, prdy = 1'b0, dn = 1'b0;
        logic [41:0] pp = '0;
`ifdef LUT_PERM_GEN_IDX_EN
        logic [12:0] pidx = '0;
`endif
        sd7 = seq7(1'b0); st7 = 1'b1; rdy7 = 1'b0;
        @(negedge clk); st7 = 1'b0;
        for (int c = 0; c < 20000 && beats < 101; c++) begin
            rdy7 = 1'($urandom_range(0, 1));
            if (pv && !prdy) begin
                total++; if (vld7 !== 1'b1 || prm7 !== pp) begin bad++; $display("FAIL hold_prm got=%b/%h want=1/%h", vld7, prm7, pp); end
`ifdef LUT_PERM_GEN_IDX_EN
                total++; if (idx7 !== pidx) begin bad++; $display("FAIL hold_idx got=%0d want=%0d", idx7, pidx); end
`endif
            end
            if (vld7 && rdy7) begin
                total++; if (prm7 !== exp_q[beats]) begin bad++; $display("FAIL rand_beat%0d got=%h want=%h", beats, prm7, exp_q[beats]); end
                beats++;
            end
            pv = vld7; prdy = rdy7; pp = prm7;
`ifdef LUT_PERM_GEN_IDX_EN
            pidx = idx7;
`endif
            @(negedge clk);
        end
        total++; if (beats !== 101) begin bad++; $display("FAIL rand_timeout got=%0d want=101", beats); end
        rdy7 = 1'b0; ab7 = 1'b1;
        @(negedge clk); ab7 = 1'b0;
        total++; if ({vld7, busy7, done7} !== 3'd0) begin bad++; $display("FAIL abort_flags got=%b want=000", {vld7, busy7, done7}); end
        total++; if (prm7 !== exp_q[100]) begin bad++; $display("FAIL abort_prm got=%h want=%h", prm7, exp_q[100]); end
        for (int c = 0; c < 10; c++) begin dn = dn | done7 | busy7; @(negedge clk); end
        total++; if (dn !== 1'b0) begin bad++; $display("FAIL abort_quiet got=%b want=0", dn); end
        st7 = 1'b1; rdy7 = 1'b0;
        @(negedge clk); st7 = 1'b0;
        total++; if ({vld7, prm7} !== {1'b1, seq7(1'b0)}) begin bad++; $display("FAIL restart got=%b/%h want=1/%h", vld7, prm7, seq7(1'b0)); end
`ifdef LUT_PERM_GEN_IDX_EN
        total++; if (idx7 !== 13'd0) begin bad++; $display("FAIL restart_idx got=%0d want=0", idx7); end
`endif
        ab7 = 1'b1;
        @(negedge clk); ab7 = 1'b0;
        total++; if (busy7 !== 1'b0) begin bad++; $display("FAIL abort2_busy got=%b want=0", busy7); end
    endtask

    task automatic test_rst_rev;
        int beats = 0;
        bit hit = 1'b0;
        sd7 = seq7(1'b0); st7 = 1'b1; rdy7 = 1'b1;
        @(negedge clk); st7 = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            if (vld7) beats++;
            if (beats >= 3 && u7.st == REV) hit = 1'b1;
            else @(negedge clk);
        end
        total++; if (!hit) begin bad++; $display("FAIL rst_rev_reach got=no_rev want=rev"); end
        #2 rst = 1'b1;
        #1;
        total++; if ({vld7, busy7, done7} !== 3'd0 || prm7 !== 42'd0) begin bad++; $display("FAIL async_rst got=%b/%h want=000/0", {vld7, busy7, done7}, prm7); end
`ifdef LUT_PERM_GEN_IDX_EN
        total++; if (idx7 !== 13'd0) begin bad++; $display("FAIL async_rst_idx got=%0d want=0", idx7); end
`endif
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        total++; if ({vld7, busy7, done7} !== 3'd0 || prm7 !== 42'd0) begin bad++; $display("FAIL post_rst_idle got=%b/%h want=000/0", {vld7, busy7, done7}, prm7); end
    endtask

    task automatic test_dup;
        int beats = 0;
        bit seen = 1'b0;
        build_exp(3, 2, 42'h10);
        sd3 = 6'h10; st3 = 1'b1; ab3 = 1'b1; rdy3 = 1'b1;
        @(negedge clk); st3 = 1'b0; ab3 = 1'b0;
        total++; if ({busy3, vld3} !== 2'b11) begin bad++; $display("FAIL start_beats_abort got=%b want=11", {busy3, vld3}); end
        for (int c = 0; c < 200 && !seen; c++) begin
            st3 = (beats == 1 && !vld3);
            sd3 = st3 ? 6'h2A : 6'h10;
            if (done3) begin
                seen = 1'b1;
                total++; if (beats !== 3) begin bad++; $display("FAIL dup_beats got=%0d want=3", beats); end
            end else if (vld3 && rdy3) begin
                total++; if (beats >= exp_q.size() || {36'd0, prm3} !== exp_q[beats]) begin bad++; $display("FAIL dup_beat%0d got=%h want=%h", beats, prm3, beats < exp_q.size() ? exp_q[beats] : 42'd0); end
                beats++;
            end
            @(negedge clk);
        end
        st3 = 1'b0;
        total++; if (!seen) begin bad++; $display("FAIL dup_timeout got=no_done want=done"); end
    endtask

    initial begin
        test_reset;
        test_small;
        test_full;
        test_rand_abort;
        test_rst_rev;
        test_dup;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
